// File: rtl/rr_bus_arbiter16_pkg.sv
// Shared constants and state encoding for the 4-way round-robin bus arbiter.
package rr_bus_arbiter16_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/Mux16.sv
// 16-bit 2:1 multiplexer.
//   a, b : data inputs
//   sel  : 0 selects a, 1 selects b
//   y    : selected word
module Mux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four request lines.
//   req   : candidate request lines
//   ptr   : index scanned first; the scan then wraps upward modulo 4
//   idx   : first set request found in scan order (ptr when none)
//   found : high when any request is set
module rr_pick4
  import rr_bus_arbiter16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan farthest-first so the closest hit to ptr is the one left standing.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      logic [IDX_W-1:0] j;
      j = ptr + IDX_W'(k);
      if (req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter16.sv
// Round-robin arbiter sharing one 16-bit datapath among four requesters,
// with each ownership limited to MAX_BURST cycles while others wait.
//   clk, rst        : clock, asynchronous active-high reset
//   req             : request lines, one per requester
//   data0..data3    : requester words
//   grant           : registered one-hot grant (or zero)
//   valid           : registered, high while a grant is held
//   owner           : registered index of current or last owner
//   out             : owner's word while valid, zero otherwise (combinational)
module rr_bus_arbiter16
  import rr_bus_arbiter16_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  output logic [N_REQ-1:0]  grant,
  output logic              valid,
  output logic [IDX_W-1:0]  owner,
  output logic [DATA_W-1:0] out
);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [N_REQ-1:0]   others;
  logic [N_REQ-1:0]   pick_req;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [DATA_W-1:0]  lo_word;
  logic [DATA_W-1:0]  hi_word;
  logic [DATA_W-1:0]  sel_word;

  // While busy the owner is excluded, so any hit is a genuine hand-off target.
  always_comb begin
    others        = req;
    others[owner] = 1'b0;
    pick_req      = (state == BUSY) ? others : req;
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Arbitration state machine; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      valid <= 1'b0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= BUSY;
            grant <= N_REQ'(1) << pick_idx;
            valid <= 1'b1;
            owner <= pick_idx;
            ptr   <= pick_idx + IDX_W'(1);
            cnt   <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (!req[owner] || (cnt >= CNT_W'(MAX_BURST) && pick_found)) begin
            if (pick_found) begin
              // Hand off on this edge, no idle bubble.
              grant <= N_REQ'(1) << pick_idx;
              owner <= pick_idx;
              ptr   <= pick_idx + IDX_W'(1);
              cnt   <= CNT_W'(1);
            end else begin
              state <= IDLE;
              grant <= '0;
              valid <= 1'b0;
            end
          end else if (cnt < CNT_W'(MAX_BURST)) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Burst limit reached with nobody waiting: restart the burst.
            cnt <= CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output datapath: 4:1 tree on owner, then gate with valid.
  Mux16 u_mux_lo  (.a(data0),   .b(data1),    .sel(owner[0]), .y(lo_word));
  Mux16 u_mux_hi  (.a(data2),   .b(data3),    .sel(owner[0]), .y(hi_word));
  Mux16 u_mux_sel (.a(lo_word), .b(hi_word),  .sel(owner[1]), .y(sel_word));
  Mux16 u_mux_out (.a(16'h0000), .b(sel_word), .sel(valid),   .y(out));

endmodule

// File: tb/tb_rr_bus_arbiter16.sv
// Self-checking bench for rr_bus_arbiter16 against a behavioural model.
module tb_rr_bus_arbiter16;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] d [4];
  logic [3:0]  grant;
  logic        valid;
  logic [1:0]  owner;
  logic [15:0] out;

  int tests  = 0;
  int failed = 0;

  // Behavioural model: who holds the bus, for how long, and who won last.
  bit m_valid;
  int m_owner;
  int m_run;
  int m_last;   // index granted most recently, -1 after reset

  always #5 clk = ~clk;

  rr_bus_arbiter16 #(.MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data0 (d[0]),
    .data1 (d[1]),
    .data2 (d[2]),
    .data3 (d[3]),
    .grant (grant),
    .valid (valid),
    .owner (owner),
    .out   (out)
  );

  function automatic int rr_first(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_owner = 0;
    m_run   = 0;
    m_last  = -1;
  endtask

  task automatic model_give(input int w);
    m_valid = 1;
    m_owner = w;
    m_run   = 1;
    m_last  = w;
  endtask

  task automatic model_edge();
    logic [3:0] waiting;
    int w;
    waiting = req;
    if (m_valid) waiting[m_owner] = 1'b0;
    w = rr_first(waiting, m_last);
    if (!m_valid) begin
      if (w >= 0) model_give(w);
    end else if (!req[m_owner]) begin
      if (w >= 0) model_give(w);
      else m_valid = 0;
    end else if (m_run < MAXB) begin
      m_run++;
    end else if (w >= 0) begin
      model_give(w);
    end else begin
      m_run = 1;
    end
  endtask

  function automatic logic [22:0] model_view();
    logic [3:0]  g;
    logic [15:0] o;
    g = m_valid ? 4'(1 << m_owner) : 4'b0000;
    o = m_valid ? d[m_owner] : 16'h0000;
    return {g, m_valid, 2'(m_owner), o};
  endfunction

  // Advance one edge, update the model with the req seen at that edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = 4'b0000;
    apply_reset();
    tests++;
    if ({grant, valid, owner, out} !== 23'd0) begin
      failed++;
      $display("FAIL reset_state got %h/%b/%0d/%h want 0", grant, valid, owner, out);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if (grant !== 4'b0 || valid !== 1'b0 || out !== 16'h0000) begin
        failed++;
        $display("FAIL idle_no_req cyc %0d got grant=%b valid=%b out=%h want 0", c, grant, valid, out);
      end
    end
    // Reset mid-burst must drop grant before the next edge.
    req = 4'b0001;
    step();
    tests++;
    if (grant !== 4'b0001) begin
      failed++;
      $display("FAIL burst_start got %b want 0001", grant);
    end
    step();
    rst = 1'b1;
    model_reset();
    #2;
    tests++;
    if (grant !== 4'b0 || valid !== 1'b0 || out !== 16'h0000) begin
      failed++;
      $display("FAIL async_reset got grant=%b valid=%b out=%h want 0", grant, valid, out);
    end
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    d[2] = 16'hBEEF;
    req  = 4'b0100;
    step();
    tests++;
    if (grant !== 4'b0100 || owner !== 2'd2 || out !== 16'hBEEF || valid !== 1'b1) begin
      failed++;
      $display("FAIL single_grant got %b/%0d/%h want 0100/2/beef", grant, owner, out);
    end
    d[2] = 16'h1234;
    #1;
    tests++;
    if (out !== 16'h1234) begin
      failed++;
      $display("FAIL data_passthrough got %h want 1234", out);
    end
    req = 4'b0000;
    step();
    tests++;
    if (valid !== 1'b0 || out !== 16'h0000 || grant !== 4'b0 || owner !== 2'd2) begin
      failed++;
      $display("FAIL single_release got v=%b out=%h g=%b own=%0d want 0/0000/0000/2",
               valid, out, grant, owner);
    end
  endtask

  task automatic test_all_req();
    apply_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
      step();
      tests++;
      if (grant !== 4'(1 << ((c / MAXB) % 4)) || valid !== 1'b1) begin
        failed++;
        $display("FAIL all_req_rotation cyc %0d got %b/%b want %b/1", c, grant, valid,
                 4'(1 << ((c / MAXB) % 4)));
      end
      tests++;
      if ({grant, valid, owner, out} !== model_view()) begin
        failed++;
        $display("FAIL all_req_model cyc %0d got %h want %h", c,
                 {grant, valid, owner, out}, model_view());
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 4'b0010;
    step();
    step();
    tests++;
    if (grant !== 4'b0010 || valid !== 1'b1) begin
      failed++;
      $display("FAIL handoff_before got %b/%b want 0010/1", grant, valid);
    end
    req = 4'b1000;
    step();
    tests++;
    if (grant !== 4'b1000 || valid !== 1'b1 || owner !== 2'd3) begin
      failed++;
      $display("FAIL handoff_after got %b/%b/%0d want 1000/1/3", grant, valid, owner);
    end
  endtask

  task automatic test_solo_hold();
    apply_reset();
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      d[1] = 16'($urandom);
      step();
      tests++;
      if (grant !== 4'b0010 || valid !== 1'b1 || out !== d[1]) begin
        failed++;
        $display("FAIL solo_hold cyc %0d got %b/%b/%h want 0010/1/%h", c, grant, valid, out, d[1]);
      end
    end
  endtask

  task automatic test_fairness();
    int wait_cnt [4];
    apply_reset();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 200; c++) begin
      req = {1'b0, 1'b1, 1'($urandom), 1'b1};
      for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
      step();
      tests++;
      if ({grant, valid, owner, out} !== model_view()) begin
        failed++;
        $display("FAIL fair_model cyc %0d got %h want %h", c,
                 {grant, valid, owner, out}, model_view());
      end
      tests++;
      if ($countones(grant) > 1 || valid !== (|grant) ||
          (valid && grant[owner] !== 1'b1) || (grant & ~req) !== 4'b0) begin
        failed++;
        $display("FAIL fair_invariant cyc %0d grant=%b valid=%b owner=%0d req=%b",
                 c, grant, valid, owner, req);
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        tests++;
        if (wait_cnt[i] > 3 * MAXB) begin
          failed++;
          $display("FAIL fair_starve req %0d cyc %0d waited %0d want <= %0d",
                   i, c, wait_cnt[i], 3 * MAXB);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 16'h0000;
    model_reset();
    test_reset();
    test_single();
    test_all_req();
    test_back_to_back();
    test_solo_hold();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter16.md
Name: rr_bus_arbiter16

Overview:
- Round-robin arbiter that shares one 16-bit datapath between four requesters.
- Each requester presents a 16-bit word and a request line. The arbiter registers a one-hot grant and steers the owner's word to a single output through a 4:1 tree of Mux16 instances.
- Sits in front of any shared 16-bit consumer, such as a register-file write port or a memory input.
- Bounds each ownership by a burst limit so no requester can starve the others.

Parameters:
- MAX_BURST, 4: maximum consecutive grant cycles for one owner while another requester is waiting. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  request lines; req[i] is high while requester i wants the bus.
- data0  in  16  word from requester 0.
- data1  in  16  word from requester 1.
- data2  in  16  word from requester 2.
- data3  in  16  word from requester 3.
- grant  out  4  registered, one-hot grant, or all zero.
- valid  out  1  registered; high when grant is non-zero.
- owner  out  2  registered index of the current or last owner.
- out  out  16  data of the current owner while valid is high; 16'h0000 otherwise.

Behaviour:
- Reset (async, rst=1):
  - grant=0, valid=0, owner=0, out=0.
  - Internal rotate pointer ptr=0, burst counter cnt=0, state=IDLE.
  - A reset mid-burst drops grant immediately, without waiting for a clock edge.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, on the next edge pick the first i with req[i]=1, scanning ptr, ptr+1, ... modulo 4.
  - Then set grant=1<<i, owner=i, cnt=1, ptr=(i+1) mod 4, and go to BUSY.
  - Latency: request high before edge t gives grant visible after edge t (1 cycle).
- State BUSY, evaluated each edge with o=owner and others = req with bit o masked:
  - req[o]=0 and others=0: grant=0, valid=0, go to IDLE. owner holds its value.
  - req[o]=0 and others!=0: switch in the same edge, with no idle bubble. The new owner is picked by the round-robin scan from ptr; cnt=1 and ptr is updated.
  - req[o]=1 and cnt<MAX_BURST: keep the owner, cnt=cnt+1.
  - req[o]=1, cnt==MAX_BURST and others!=0: forced switch by round-robin from ptr; cnt=1.
  - req[o]=1, cnt==MAX_BURST and others=0: keep the owner, cnt=1 (the burst restarts).
- Round-robin: ptr always points one past the last granted index, so a requester that was just granted has lowest priority on the next arbitration.
- cnt is 4 bits and saturation-free: it never exceeds MAX_BURST.
- out datapath:
  - Combinational from the registered owner/valid.
  - Two Mux16 instances select on owner[0]: one between data0 and data1, one between data2 and data3.
  - A third Mux16 selects between those two results on owner[1].
  - A final Mux16 selects between 16'h0000 and that result on valid.
  - A change on data lines propagates to out in the same cycle.
- Invariants:
  - grant has at most one bit set.
  - valid == |grant.
  - grant[owner]==1 whenever valid is high.
  - The arbiter never grants a requester whose req was low at the arbitration edge.

Decomposition:
- Shared package/header: N_REQ=4, IDX_W=2, DATA_W=16, state encodings IDLE=1'b0 and BUSY=1'b1.
- The round-robin pick (req, ptr in; index, found out) is a natural sub-module: rr_pick4, purely combinational.
- The datapath reuses the existing Mux16; no new mux module.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles: grant=0, valid=0, out=16'h0000 throughout. Then assert rst mid-burst: grant drops before the next edge.
- req=4'b0100, data2=16'hBEEF: after 1 edge grant=4'b0100, owner=2, out=16'hBEEF. Drop req: the next edge gives valid=0, out=0.
- req=4'b1111 held, MAX_BURST=4, from reset:
  - Grants go to requester 0 for 4 cycles, then 1, 2, 3 for 4 cycles each, then back to 0.
  - No idle cycles occur between owners.
- Owner 1 active with req=4'b0010; at cycle 2, set req=4'b1000 (owner drops, 3 raises): grant goes directly 0010->1000 on one edge, with valid high throughout.
- Only req[1] held for 10 cycles with MAX_BURST=4: grant stays 4'b0010 continuously while cnt wraps 4->1.
- Fairness: hold req[0] and req[2] high and toggle req[1] for 200 random cycles. No waiting requester waits more than 3*MAX_BURST cycles, and the one-hot/valid invariants hold every cycle.
